counter_display_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/counter_display_driver_if.sv | 33 +++
 rtl/bcd_wrap_counter.sv | 45 ++++
 rtl/counter_display_driver.sv | 124 ++++++++++++
 tb/tb_counter_display_driver.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path.
// Provides the digit count, active-low blank/off constants, the display
// payload struct driven onto the pins, and the hex-to-segment decoder.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

    // One sample of everything the display pins carry.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [SEG_W-1:0]      seg;
        logic                  dp;
    } disp_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/counter_display_driver_if.sv
// Pin-level bundle between the upstream counter / display and the driver.
//   count_in : 4-bit value from the upstream counter
//   an       : digit anodes, active low, an[0] = rightmost digit
//   seg      : segments {g,f,e,d,c,b,a}, active low
//   dp       : decimal point, active low
//   wrap_o   : one-cycle pulse per detected F->0 wrap
// master = the display driver, slave = whoever feeds/observes it.
interface counter_display_driver_if;
    import seg7_pkg::*;

    logic [NIBBLE_W-1:0]   count_in;
    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      seg;
    logic                  dp;
    logic                  wrap_o;

    modport master (
        input  count_in,
        output an,
        output seg,
        output dp,
        output wrap_o
    );

    modport slave (
        output count_in,
        input  an,
        input  seg,
        input  dp,
        input  wrap_o
    );

endinterface

// File: rtl/bcd_wrap_counter.sv
// Three-digit BCD event counter with a sticky overflow flag.
//   clk, reset            : clock, asynchronous active-high reset
//   inc                   : count one event this cycle
//   hundreds, tens, ones  : BCD digits of the running count
//   overflow              : set when 999 rolls to 000, cleared only by reset
module bcd_wrap_counter
    import seg7_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    output logic [NIBBLE_W-1:0] hundreds,
    output logic [NIBBLE_W-1:0] tens,
    output logic [NIBBLE_W-1:0] ones,
    output logic                overflow
);

    // Ripple the decimal carry ones -> tens -> hundreds -> overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (ones == 4'd9) begin
                ones <= '0;
                if (tens == 4'd9) begin
                    tens <= '0;
                    if (hundreds == 4'd9) begin
                        hundreds <= '0;
                        overflow <= 1'b1;
                    end else begin
                        hundreds <= 4'(hundreds + 4'd1);
                    end
                end else begin
                    tens <= 4'(tens + 4'd1);
                end
            end else begin
                ones <= 4'(ones + 4'd1);
            end
        end
    end

endmodule

// File: rtl/counter_display_driver.sv
// Four-digit multiplexed common-anode display driver for a 4-bit counter.
// Digit 0 shows the live counter value in hex, digits 3..1 show a BCD count
// of F->0 wraps with leading-zero blanking on digits 3 and 2. Each digit slot
// lasts SCAN_DIV cycles and starts with BLANK_CYCLES of all-anodes-off to
// suppress ghosting. dp lights on digit 3 once the wrap count has overflowed.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : count_in in; an, seg, dp, wrap_o out (all registered)
module counter_display_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    counter_display_driver_if.master  bus
);

    localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);

    // Reject parameter sets that would give no slot or no lit phase.
    generate
        if (SCAN_DIV < 2 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
            $error("counter_display_driver: need SCAN_DIV >= 2 and BLANK_CYCLES < SCAN_DIV");
        end
    endgenerate

    logic [NIBBLE_W-1:0] count_r;
    logic [NIBBLE_W-1:0] prev_r;
    logic                wrap_det_c;
    logic                wrap_q;

    logic [PRE_W-1:0]    prescaler;
    logic [IDX_W-1:0]    idx;

    logic [NIBBLE_W-1:0] hundreds;
    logic [NIBBLE_W-1:0] tens;
    logic [NIBBLE_W-1:0] ones;
    logic                overflow;

    logic [SEG_W-1:0]    digit_seg_c;
    disp_t               disp_d_c;
    disp_t               disp_q;

    // Wrap is seen as the last two captured samples going F then 0.
    assign wrap_det_c = (prev_r == 4'hF) && (count_r == 4'h0);

    // Input capture and wrap pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
            prev_r  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_r <= bus.count_in;
            prev_r  <= count_r;
            wrap_q  <= wrap_det_c;
        end
    end

    bcd_wrap_counter u_bcd (
        .clk      (clk),
        .reset    (reset),
        .inc      (wrap_det_c),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .overflow (overflow)
    );

    // Slot prescaler and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            idx       <= IDX_W'(idx + IDX_W'(1));
        end else begin
            prescaler <= PRE_W'(prescaler + PRE_W'(1));
        end
    end

    // Pattern for the digit currently selected, with leading-zero blanking.
    always_comb begin
        digit_seg_c = SEG_BLANK;
        case (idx)
            2'd0: digit_seg_c = hex_to_seg(count_r);
            2'd1: digit_seg_c = hex_to_seg(ones);
            2'd2: if (hundreds != 4'd0 || tens != 4'd0) digit_seg_c = hex_to_seg(tens);
            default: if (hundreds != 4'd0) digit_seg_c = hex_to_seg(hundreds);
        endcase
    end

    // Pin values: everything off during the blank interval, else one anode lit.
    always_comb begin
        disp_d_c.an  = AN_OFF;
        disp_d_c.seg = SEG_BLANK;
        disp_d_c.dp  = 1'b1;
        if (prescaler >= PRE_BLANK) begin
            disp_d_c.an  = ~(4'b0001 << idx);
            disp_d_c.seg = digit_seg_c;
            disp_d_c.dp  = ~((idx == 2'd3) && overflow);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q.an  <= AN_OFF;
            disp_q.seg <= SEG_BLANK;
            disp_q.dp  <= 1'b1;
        end else begin
            disp_q <= disp_d_c;
        end
    end

    assign bus.an     = disp_q.an;
    assign bus.seg    = disp_q.seg;
    assign bus.dp     = disp_q.dp;
    assign bus.wrap_o = wrap_q;

endmodule

// File: tb/tb_counter_display_driver.sv
// Bench for counter_display_driver with a short scan (SCAN_DIV=8, BLANK=2).
module tb_counter_display_driver;

    localparam int unsigned SD  = 8;
    localparam int unsigned BLK = 2;

    logic clk = 1'b0;
    logic reset;

    counter_display_driver_if dif();

    counter_display_driver #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference state: cycles since reset, last two samples taken, wrap total.
    int unsigned cyc;
    logic [3:0]  h0;
    logic [3:0]  h1;
    int unsigned wraps;
    int unsigned pulses;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [6:0] cap [4];
    logic       cap_dp3;

    typedef struct {
        logic [3:0] cin;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       wrap;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t, cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        h0     = 4'h0;
        h1     = 4'h0;
        wraps  = 0;
    endtask

    // Expected pins for a given time since reset, displayed hex value and wrap total.
    task automatic expect_disp(input int unsigned c, input logic [3:0] cr, input int unsigned w,
                               output logic [3:0] ean, output logic [6:0] eseg, output logic edp);
        int unsigned p, d, wm;
        p  = c % SD;
        d  = (c / SD) % 4;
        wm = w % 1000;
        ean  = 4'hF;
        eseg = 7'h7F;
        edp  = 1'b1;
        if (p >= BLK) begin
            ean = ~(4'(1) << d);
            case (d)
                0: eseg = hex_tab[cr];
                1: eseg = hex_tab[wm % 10];
                2: eseg = (wm < 10)  ? 7'h7F : hex_tab[(wm / 10) % 10];
                default: eseg = (wm < 100) ? 7'h7F : hex_tab[wm / 100];
            endcase
            edp = !(d == 3 && w >= 1000);
        end
    endtask

    // Present v for one clock and compare every output against the model.
    task automatic tick(input logic [3:0] v);
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        logic       ewrap;
        dif.count_in = v;
        @(posedge clk);
        #1;
        expect_disp(cyc, h0, wraps, ean, eseg, edp);
        ewrap = (h1 == 4'hF) && (h0 == 4'h0);
        chk("an",     32'(dif.an),     32'(ean));
        chk("seg",    32'(dif.seg),    32'(eseg));
        chk("dp",     32'(dif.dp),     32'(edp));
        chk("wrap_o", 32'(dif.wrap_o), 32'(ewrap));
        if (dif.wrap_o) pulses++;
        if (ewrap) wraps++;
        h1 = h0;
        h0 = v;
        cyc++;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic add_wraps(input int n);
        for (int i = 0; i < n; i++) begin
            tick(4'hF);
            tick(4'h0);
        end
    endtask

    // Walk a full scan holding v and record what each lit digit showed.
    task automatic capture(input logic [3:0] v);
        for (int i = 0; i < 4; i++) cap[i] = 7'h55;
        cap_dp3 = 1'b0;
        for (int i = 0; i < 4 * SD + 2; i++) begin
            tick(v);
            case (dif.an)
                4'b1110: cap[0] = dif.seg;
                4'b1101: cap[1] = dif.seg;
                4'b1011: cap[2] = dif.seg;
                4'b0111: begin cap[3] = dif.seg; cap_dp3 = dif.dp; end
                default: ;
            endcase
        end
    endtask

    task automatic chk_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic dp3);
        chk({tag, "_d1"},  32'(cap[1]),  32'(d1));
        chk({tag, "_d2"},  32'(cap[2]),  32'(d2));
        chk({tag, "_d3"},  32'(cap[3]),  32'(d3));
        chk({tag, "_dp3"}, 32'(cap_dp3), 32'(dp3));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
    task automatic async_reset(input string tag, input int hold_ns);
        #3;
        reset = 1'b1;
        #1;
        chk({tag, "_an_now"},   32'(dif.an),     32'(4'hF));
        chk({tag, "_seg_now"},  32'(dif.seg),    32'(7'h7F));
        chk({tag, "_dp_now"},   32'(dif.dp),     32'(1'b1));
        chk({tag, "_wrap_now"}, 32'(dif.wrap_o), 32'(1'b0));
        #(hold_ns - 1);
        chk({tag, "_an_held"},  32'(dif.an),     32'(4'hF));
        chk({tag, "_seg_held"}, 32'(dif.seg),    32'(7'h7F));
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t slot_tab [4];
        vec_t vecs [$];
        logic found;

        // Expected lit-phase pins per slot while count_in is held at A.
        slot_tab[0] = '{cin: 4'hA, an: 4'b1110, seg: 7'h08, dp: 1'b1, wrap: 1'b0};
        slot_tab[1] = '{cin: 4'hA, an: 4'b1101, seg: 7'h40, dp: 1'b1, wrap: 1'b0};
        slot_tab[2] = '{cin: 4'hA, an: 4'b1011, seg: 7'h7F, dp: 1'b1, wrap: 1'b0};
        slot_tab[3] = '{cin: 4'hA, an: 4'b0111, seg: 7'h7F, dp: 1'b1, wrap: 1'b0};
        for (int i = 0; i < 8 * SD; i++) begin
            vec_t v;
            v = slot_tab[(i / SD) % 4];
            if ((i % SD) < BLK) begin
                v.an  = 4'hF;
                v.seg = 7'h7F;
                v.dp  = 1'b1;
            end
            vecs.push_back(v);
        end

        reset = 1'b1;
        dif.count_in = 4'h0;
        model_reset();
        pulses = 0;
        #23;
        chk("por_an",  32'(dif.an),  32'(4'hF));
        chk("por_seg", 32'(dif.seg), 32'(7'h7F));
        reset = 1'b0;
        model_reset();

        // Reset while a digit is lit and wrap_o is high.
        hold(4'hA, 4);
        tick(4'hF);
        tick(4'h0);
        tick(4'h0);
        chk("pre_reset_wrap", 32'(dif.wrap_o), 32'(1'b1));
        async_reset("t1", 20);

        // Fixed scan pattern with count_in = A.
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].cin);
            chk("t2_an",   32'(dif.an),     32'(vecs[i].an));
            chk("t2_seg",  32'(dif.seg),    32'(vecs[i].seg));
            chk("t2_dp",   32'(dif.dp),     32'(vecs[i].dp));
            chk("t2_wrap", 32'(dif.wrap_o), 32'(vecs[i].wrap));
        end

        // Counter mirror: three F->0 wraps.
        async_reset("t3r", 20);
        pulses = 0;
        for (int i = 0; i < 48; i++) tick(4'(i));
        tick(4'h0);
        hold(4'h0, 3);
        chk("t3_pulses", 32'(pulses), 32'd3);
        capture(4'h0);
        chk("t3_d0", 32'(cap[0]), 32'(7'h40));
        chk_digits("t3", 7'h7F, 7'h7F, 7'h30, 1'b1);

        // Only a true F->0 counts, however long 0 is held.
        async_reset("t4r", 20);
        pulses = 0;
        tick(4'hF); tick(4'h3); tick(4'hE); tick(4'h0); tick(4'hF);
        hold(4'h0, 10);
        hold(4'h0, 3);
        chk("t4_pulses", 32'(pulses), 32'd1);
        capture(4'h0);
        chk_digits("t4", 7'h7F, 7'h7F, 7'h79, 1'b1);

        // 123 wraps, then roll through 999 to 000 with overflow.
        async_reset("t5r", 20);
        add_wraps(123);
        hold(4'h0, 3);
        capture(4'h0);
        chk_digits("t5a", 7'h79, 7'h24, 7'h30, 1'b1);
        add_wraps(877);
        hold(4'h0, 3);
        capture(4'h0);
        chk_digits("t5b", 7'h7F, 7'h7F, 7'h40, 1'b0);

        // Reach 045 (overflow still set), reset mid digit-2 slot.
        add_wraps(45);
        hold(4'h0, 3);
        capture(4'h0);
        chk_digits("t6a", 7'h7F, 7'h19, 7'h12, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 4 * SD + 2 && !found; i++) begin
            tick(4'h0);
            if (dif.an == 4'b1011) found = 1'b1;
        end
        chk("t6_find_d2", 32'(found), 32'(1'b1));
        async_reset("t6r", 10);
        tick(4'h0);
        chk("t6_blank0", 32'(dif.an), 32'(4'hF));
        tick(4'h0);
        chk("t6_blank1", 32'(dif.an), 32'(4'hF));
        tick(4'h0);
        chk("t6_first_an", 32'(dif.an), 32'(4'b1110));
        capture(4'h0);
        chk_digits("t6b", 7'h7F, 7'h7F, 7'h40, 1'b1);

        // Random stream biased toward F and 0 so wraps are frequent.
        async_reset("t7r", 20);
        for (int i = 0; i < 1200; i++) begin
            logic [3:0] v;
            case ($urandom_range(0, 3))
                0: v = 4'hF;
                1: v = 4'h0;
                default: v = 4'($urandom_range(0, 15));
            endcase
            tick(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
